// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calc_arbiter slice:
//   OPND_W          operand / result width
//   OP_ADD..OP_DIV  2-bit opcode encodings
//   state_t         FSM state encoding (IDLE, EXEC, RESP)
//   is_div_zero()   detects a divide request whose divisor is zero
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int OPND_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A divide by zero skips the datapath entirely and answers at once.
    function automatic logic is_div_zero(input logic [1:0]        sel,
                                         input logic [OPND_W-1:0] b);
        return (sel == OP_DIV) && (b == {OPND_W{1'b0}});
    endfunction

endpackage

// File: rtl/calculator.sv
// -----------------------------------------------------------------------------
// calculator
// Combinational signed-magnitude datapath.
//   Rst       forces both results to zero while asserted
//   i_a/i_b   operand magnitudes, i_sign_a/i_sign_b signs (1 = negative)
//   i_sel     opcode (add, sub, mul, div)
//   o_out     two's complement result truncated to OPND_W bits
//             (division: magnitude quotient, negated when signs differ)
//   o_rem     magnitude remainder for divide, 0 otherwise
// -----------------------------------------------------------------------------
module calculator
    import calc_pkg::*;
(
    input  logic              Rst,
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    input  logic [1:0]        i_sel,
    input  logic              i_sign_a,
    input  logic              i_sign_b,
    output logic [OPND_W-1:0] o_out,
    output logic [OPND_W-1:0] o_rem
);

    logic [OPND_W-1:0]   w_sa;
    logic [OPND_W-1:0]   w_sb;
    logic [2*OPND_W-1:0] w_prod;
    logic [OPND_W-1:0]   w_quo;
    logic [OPND_W-1:0]   w_mod;
    logic                w_neg;
    logic [OPND_W-1:0]   w_res;
    logic [OPND_W-1:0]   w_rem;

    // Signed-magnitude operands mapped to two's complement for add/sub.
    assign w_sa   = i_sign_a ? ({OPND_W{1'b0}} - i_a) : i_a;
    assign w_sb   = i_sign_b ? ({OPND_W{1'b0}} - i_b) : i_b;
    assign w_neg  = i_sign_a ^ i_sign_b;
    assign w_prod = {{OPND_W{1'b0}}, i_a} * {{OPND_W{1'b0}}, i_b};
    // Zero divisor never reaches capture, but keep the divider X-free.
    assign w_quo  = (i_b == {OPND_W{1'b0}}) ? {OPND_W{1'b0}} : (i_a / i_b);
    assign w_mod  = (i_b == {OPND_W{1'b0}}) ? {OPND_W{1'b0}} : (i_a % i_b);

    // Opcode decode.
    always_comb begin
        w_res = {OPND_W{1'b0}};
        w_rem = {OPND_W{1'b0}};
        case (i_sel)
            OP_ADD: w_res = w_sa + w_sb;
            OP_SUB: w_res = w_sa - w_sb;
            OP_MUL: w_res = w_neg ? ({OPND_W{1'b0}} - w_prod[OPND_W-1:0])
                                  : w_prod[OPND_W-1:0];
            OP_DIV: begin
                w_res = w_neg ? ({OPND_W{1'b0}} - w_quo) : w_quo;
                w_rem = w_mod;
            end
            default: begin
                w_res = {OPND_W{1'b0}};
                w_rem = {OPND_W{1'b0}};
            end
        endcase
    end

    // Reset masks the outputs.
    always_comb begin
        o_out = {OPND_W{1'b0}};
        o_rem = {OPND_W{1'b0}};
        if (Rst) begin
            o_out = {OPND_W{1'b0}};
            o_rem = {OPND_W{1'b0}};
        end else begin
            o_out = w_res;
            o_rem = w_rem;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   Clk, Rst  clock and synchronous active-high reset (pointer -> 0)
//   i_req     request vector, bit i = requester i
//   i_take    grant is being consumed this cycle (pointer may advance)
//   o_gnt     one-hot grant (combinational from i_req and the pointer)
// After any consumed grant the pointer names the other requester.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Grant selection: a lone request wins outright, a tie goes to the pointer.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // Pointer update: point away from whoever was just served.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr <= 1'b0;
        end else if (i_take && (i_req != 2'b00)) begin
            r_ptr <= ~o_gnt[1];
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// -----------------------------------------------------------------------------
// calc_arbiter
// Arbitrates two requesters onto one calculator datapath.
//   Clk, Rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (ready is a 1-cycle grant)
//   req_A, req_B             8-bit magnitudes, [7:0] req0, [15:8] req1
//   req_Sel                  opcodes, [1:0] req0, [3:2] req1
//   req_Sign_A, req_Sign_B   operand signs per requester
//   rsp_valid / rsp_ready    response handshake, response held until taken
//   rsp_id, rsp_out, rsp_R   owner, result, remainder
//   rsp_dz                   divide-by-zero flag
//   busy                     high whenever not IDLE
// Operands are held SETTLE cycles on the datapath before the result is captured.
// -----------------------------------------------------------------------------
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [15:0]       req_A,
    input  logic [15:0]       req_B,
    input  logic [3:0]        req_Sel,
    input  logic [1:0]        req_Sign_A,
    input  logic [1:0]        req_Sign_B,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [OPND_W-1:0] rsp_out,
    output logic [OPND_W-1:0] rsp_R,
    output logic              rsp_dz,
    output logic              busy
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [OPND_W-1:0] r_a;
    logic [OPND_W-1:0] r_b;
    logic [1:0]        r_sel;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_id;
    logic [OPND_W-1:0] r_out;
    logic [OPND_W-1:0] r_rem;
    logic              r_dz;
    logic              r_rsp_valid;

    logic [1:0]        w_gnt;
    logic              w_idle;
    logic              w_gid;
    logic [OPND_W-1:0] w_a;
    logic [OPND_W-1:0] w_b;
    logic [1:0]        w_sel;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [OPND_W-1:0] w_calc_out;
    logic [OPND_W-1:0] w_calc_rem;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign w_idle = (r_state == ST_IDLE) && !Rst;

    rr_arb2 u_arb (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_req  (req_valid),
        .i_take (w_idle),
        .o_gnt  (w_gnt)
    );

    assign req_ready = w_idle ? w_gnt : 2'b00;

    // Payload of the granted requester.
    assign w_gid    = w_gnt[1];
    assign w_a      = w_gid ? req_A[15:8] : req_A[7:0];
    assign w_b      = w_gid ? req_B[15:8] : req_B[7:0];
    assign w_sel    = w_gid ? req_Sel[3:2] : req_Sel[1:0];
    assign w_sign_a = w_gid ? req_Sign_A[1] : req_Sign_A[0];
    assign w_sign_b = w_gid ? req_Sign_B[1] : req_Sign_B[0];

    calculator u_calc (
        .Rst      (Rst),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sel    (r_sel),
        .i_sign_a (r_sign_a),
        .i_sign_b (r_sign_b),
        .o_out    (w_calc_out),
        .o_rem    (w_calc_rem)
    );

    // Control FSM with operand, result and response registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_a         <= {OPND_W{1'b0}};
            r_b         <= {OPND_W{1'b0}};
            r_sel       <= 2'b00;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_id        <= 1'b0;
            r_out       <= {OPND_W{1'b0}};
            r_rem       <= {OPND_W{1'b0}};
            r_dz        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_sel    <= w_sel;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_id     <= w_gid;
                        if (is_div_zero(w_sel, w_b)) begin
                            r_out       <= {OPND_W{1'b0}};
                            r_rem       <= {OPND_W{1'b0}};
                            r_dz        <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            // r_cnt counts EXEC cycles starting at 1.
                            r_cnt   <= 4'd1;
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == SETTLE_C) begin
                        r_out       <= w_calc_out;
                        r_rem       <= (r_sel == OP_DIV) ? w_calc_rem : {OPND_W{1'b0}};
                        r_dz        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_out   = r_out;
    assign rsp_R     = r_rem;
    assign rsp_dz    = r_dz;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed table, corner sequences and
// randomized rounds against a behavioural arithmetic model.
module tb_calc_arbiter;

    localparam int SETTLE = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_A;
    logic [15:0] req_B;
    logic [3:0]  req_Sel;
    logic [1:0]  req_Sign_A;
    logic [1:0]  req_Sign_B;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_out;
    logic [7:0]  rsp_R;
    logic        rsp_dz;
    logic        busy;

    always #5 Clk = ~Clk;

    calc_arbiter #(.SETTLE(SETTLE)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_Sel    (req_Sel),
        .req_Sign_A (req_Sign_A),
        .req_Sign_B (req_Sign_B),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_R      (rsp_R),
        .rsp_dz     (rsp_dz),
        .busy       (busy)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    // payload currently presented by each requester
    int pa[2], pb[2], psel[2], psa[2], psb[2];

    // observations of the last round, in grant/response order
    int o_gnt[2], o_id[2], o_out[2], o_rem[2], o_dz[2], o_lat[2];
    int o_nr;

    typedef struct {
        int r, sel, a, b, sa, sb;
        int e_out, e_rem, e_dz, e_lat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_payload(input int r, input int a, input int b,
                               input int sel, input int sa, input int sb);
        pa[r] = a; pb[r] = b; psel[r] = sel; psa[r] = sa; psb[r] = sb;
        if (r == 0) begin
            req_A[7:0]    = 8'(a);
            req_B[7:0]    = 8'(b);
            req_Sel[1:0]  = 2'(sel);
            req_Sign_A[0] = 1'(sa);
            req_Sign_B[0] = 1'(sb);
        end else begin
            req_A[15:8]   = 8'(a);
            req_B[15:8]   = 8'(b);
            req_Sel[3:2]  = 2'(sel);
            req_Sign_A[1] = 1'(sa);
            req_Sign_B[1] = 1'(sb);
        end
    endtask

    // Reference arithmetic on signed integers, reduced modulo 256.
    function automatic void ref_calc(input int sel, input int a, input int b,
                                     input int sa, input int sb,
                                     output int out, output int rem,
                                     output int dz, output int lat);
        int va;
        int vb;
        va  = (sa != 0) ? -a : a;
        vb  = (sb != 0) ? -b : b;
        rem = 0;
        dz  = 0;
        lat = SETTLE + 1;
        case (sel)
            0:       out = (va + vb) & 255;
            1:       out = (va - vb) & 255;
            2:       out = (va * vb) & 255;
            default: begin
                if (b == 0) begin
                    out = 0; dz = 1; lat = 1;
                end else begin
                    out = ((sa != sb) ? -(a / b) : (a / b)) & 255;
                    rem = a % b;
                end
            end
        endcase
    endfunction

    // Present requests in 'mask' until granted, collect all responses.
    // Entered and left one time unit after a rising edge.
    task automatic run_round(input logic [1:0] mask, input bit stall);
        int   gcyc[2];
        int   cyc;
        int   want;
        int   ng;
        bit   in_resp;
        int   held;
        logic [1:0] pending;
        pending = mask;
        want    = (mask == 2'b11) ? 2 : 1;
        cyc = 0; ng = 0; o_nr = 0; in_resp = 1'b0; held = 0;
        for (int k = 0; k < 2; k++) begin
            gcyc[k] = 0; o_gnt[k] = -1; o_id[k] = -1; o_out[k] = -1;
            o_rem[k] = -1; o_dz[k] = -1; o_lat[k] = -1;
        end
        while (o_nr < want && cyc < 300) begin
            req_valid = pending;
            rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge Clk);
            if (req_ready != 2'b00) begin
                chk("grant_only_idle", int'(busy), 0);
                if (ng < 2) begin
                    o_gnt[ng] = int'(req_ready);
                    gcyc[ng]  = cyc;
                    ng++;
                end
                pending = pending & ~req_ready;
            end
            if (rsp_valid) begin
                if (!in_resp) begin
                    in_resp  = 1'b1;
                    o_lat[o_nr] = cyc - gcyc[o_nr];
                    held = int'({rsp_id, rsp_dz, rsp_R, rsp_out});
                end else begin
                    chk("rsp_stable", int'({rsp_id, rsp_dz, rsp_R, rsp_out}), held);
                end
                if (rsp_ready) begin
                    o_id[o_nr]  = int'(rsp_id);
                    o_out[o_nr] = int'(rsp_out);
                    o_rem[o_nr] = int'(rsp_R);
                    o_dz[o_nr]  = int'(rsp_dz);
                    o_nr++;
                    in_resp = 1'b0;
                end
            end
            @(posedge Clk); #1;
            cyc++;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        chk("round_done", o_nr, want);
    endtask

    // Compare the last round against the model and advance the model pointer.
    task automatic check_round(input logic [1:0] mask);
        int order[2];
        int n;
        int eo, er, ed, el;
        if (mask == 2'b11) begin
            order[0] = m_ptr; order[1] = 1 - m_ptr; n = 2;
        end else begin
            order[0] = (mask == 2'b10) ? 1 : 0; order[1] = 0; n = 1;
        end
        for (int k = 0; k < n; k++) begin
            ref_calc(psel[order[k]], pa[order[k]], pb[order[k]],
                     psa[order[k]], psb[order[k]], eo, er, ed, el);
            chk("rnd_gnt", o_gnt[k], 1 << order[k]);
            chk("rnd_id",  o_id[k],  order[k]);
            chk("rnd_out", o_out[k], eo);
            chk("rnd_rem", o_rem[k], er);
            chk("rnd_dz",  o_dz[k],  ed);
            chk("rnd_lat", o_lat[k], el);
            m_ptr = 1 - order[k];
        end
    endtask

    initial begin
        //           r sel   a    b sa sb  out rem dz lat
        tbl[0]  = '{0, 0,   5,   3, 0, 0,   8, 0, 0, 3};
        tbl[1]  = '{1, 3,   9,   0, 0, 0,   0, 0, 1, 1};
        tbl[2]  = '{0, 1,   3,   5, 0, 0, 254, 0, 0, 3};
        tbl[3]  = '{1, 2,   3,   4, 1, 0, 244, 0, 0, 3};
        tbl[4]  = '{0, 3,  20,   3, 1, 0, 250, 2, 0, 3};
        tbl[5]  = '{1, 0, 200, 100, 0, 0,  44, 0, 0, 3};
        tbl[6]  = '{0, 2,  16,  16, 0, 0,   0, 0, 0, 3};
        tbl[7]  = '{1, 3, 255, 255, 0, 0,   1, 0, 0, 3};
        tbl[8]  = '{0, 0,   5,   3, 1, 1, 248, 0, 0, 3};
        tbl[9]  = '{1, 1,   7,   9, 0, 1,  16, 0, 0, 3};
        tbl[10] = '{0, 0,   7,   0, 0, 0,   7, 0, 0, 3};
        tbl[11] = '{1, 3, 100,   7, 1, 1,  14, 2, 0, 3};
        tbl[12] = '{0, 3,  50,   0, 1, 1,   0, 0, 1, 1};

        req_A = 16'd0; req_B = 16'd0; req_Sel = 4'd0;
        req_Sign_A = 2'd0; req_Sign_B = 2'd0; rsp_ready = 1'b0;

        // reset has priority over pending requests
        Rst = 1'b1;
        req_valid = 2'b11;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("rst_no_ready", int'(req_ready), 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        req_valid = 2'b00;
        @(negedge Clk);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_out",   int'(rsp_out), 0);
        chk("rst_R",     int'(rsp_R), 0);
        chk("rst_id",    int'(rsp_id), 0);
        chk("rst_dz",    int'(rsp_dz), 0);
        @(posedge Clk); #1;
        m_ptr = 0;

        // both valid after reset: req0 mul first, then req1 div
        set_payload(0, 12, 10, 2, 0, 0);
        set_payload(1, 100, 7, 3, 0, 0);
        run_round(2'b11, 1'b0);
        chk("both_gnt0", o_gnt[0], 1);
        chk("both_out0", o_out[0], 120);
        chk("both_id0",  o_id[0], 0);
        chk("both_gnt1", o_gnt[1], 2);
        chk("both_out1", o_out[1], 14);
        chk("both_rem1", o_rem[1], 2);
        chk("both_id1",  o_id[1], 1);
        m_ptr = 0;

        // directed single-requester table
        for (int i = 0; i < 13; i++) begin
            set_payload(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].sa, tbl[i].sb);
            run_round(2'(1 << tbl[i].r), 1'b0);
            chk("tbl_gnt", o_gnt[0], 1 << tbl[i].r);
            chk("tbl_id",  o_id[0],  tbl[i].r);
            chk("tbl_out", o_out[0], tbl[i].e_out);
            chk("tbl_rem", o_rem[0], tbl[i].e_rem);
            chk("tbl_dz",  o_dz[0],  tbl[i].e_dz);
            chk("tbl_lat", o_lat[0], tbl[i].e_lat);
            m_ptr = 1 - tbl[i].r;
        end

        // response back-pressure with a second req0 waiting
        set_payload(0, 40, 2, 0, 0, 0);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge Clk);
        chk("bp_grant", int'(req_ready), 1);
        @(posedge Clk); #1;
        for (int c = 0; c < SETTLE; c++) begin
            @(negedge Clk);
            chk("bp_exec_ready", int'(req_ready), 0);
            chk("bp_exec_valid", int'(rsp_valid), 0);
            @(posedge Clk); #1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_hold_out",   int'(rsp_out), 42);
            chk("bp_hold_ready", int'(req_ready), 0);
            @(posedge Clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        chk("bp_hs_valid", int'(rsp_valid), 1);
        chk("bp_hs_ready", int'(req_ready), 0);
        @(posedge Clk); #1;
        rsp_ready = 1'b0;
        @(negedge Clk);
        chk("bp_next_grant", int'(req_ready), 1);
        @(posedge Clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (SETTLE) @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("bp_second_valid", int'(rsp_valid), 1);
        chk("bp_second_out",   int'(rsp_out), 42);
        @(posedge Clk); #1;
        rsp_ready = 1'b0;
        m_ptr = 1;

        // reset in the second EXEC cycle aborts the operation
        set_payload(0, 3, 3, 2, 0, 0);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(negedge Clk);
        chk("abort_grant", int'(req_ready), 1);
        @(posedge Clk); #1;
        req_valid = 2'b00;
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_valid", int'(rsp_valid), 0);
        chk("abort_busy",  int'(busy), 0);
        chk("abort_out",   int'(rsp_out), 0);
        chk("abort_R",     int'(rsp_R), 0);
        chk("abort_id",    int'(rsp_id), 0);
        chk("abort_dz",    int'(rsp_dz), 0);
        chk("abort_ready", int'(req_ready), 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        @(posedge Clk); #1;
        m_ptr = 0;
        // pointer back at 0: a tie goes to req0
        set_payload(0, 1, 2, 0, 0, 0);
        set_payload(1, 9, 4, 1, 0, 0);
        run_round(2'b11, 1'b0);
        check_round(2'b11);

        // randomized rounds against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                int bv;
                bv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
                set_payload(r, int'($urandom_range(0, 255)), bv,
                            int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            end
            run_round(mask, 1'($urandom_range(0, 1)));
            check_round(mask);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: SETTLE, default 2, number of EXEC cycles the operands are held stable on the datapath before capture (legal 1..15).
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept strobe; at most one bit high, one cycle per accepted request.
REQ-006 req_A  input  16  operand A magnitudes, [7:0] requester 0, [15:8] requester 1.
REQ-007 req_B  input  16  operand B magnitudes, same packing as req_A.
REQ-008 req_Sel  input  4  opcodes, [1:0] requester 0, [3:2] requester 1; 00 add, 01 sub, 10 mul, 11 div.
REQ-009 req_Sign_A  input  2  sign of A per requester, 1 = negative.
REQ-010 req_Sign_B  input  2  sign of B per requester, 1 = negative.
REQ-011 rsp_valid  output  1  response valid; held until rsp_ready.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_id  output  1  requester index owning the current response.
REQ-014 rsp_out  output  8  captured datapath result (sum, difference, product or quotient).
REQ-015 rsp_R  output  8  captured remainder; 0 for non-divide ops.
REQ-016 rsp_dz  output  1  divide-by-zero flag for the current response.
REQ-017 busy  output  1  high in every state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP; encoding from the shared package.
REQ-019 IDLE: if any req_valid bit is high, grant one requester, pulse its req_ready for that cycle, latch its A, B, Sel, Sign_A, Sign_B into operand registers, latch rsp_id.
REQ-020 Both valid in the same cycle: grant the requester indicated by the round-robin pointer; pointer then points to the other requester.
REQ-021 Single valid: grant it regardless of pointer; pointer then points to the other requester.
REQ-022 Requesters SHALL hold valid and payload stable until ready; a valid dropped before grant is not served.
REQ-023 Grant with Sel=11 and B=0: go directly to RESP next cycle with rsp_out=0, rsp_R=0, rsp_dz=1; the datapath is not used.
REQ-024 Otherwise IDLE -> EXEC; registered operands drive the Calculator datapath for exactly SETTLE cycles, then rsp_out/rsp_R are captured and the state becomes RESP with rsp_dz=0.
REQ-025 Latency: grant in cycle t -> rsp_valid first high in cycle t+SETTLE+1 (t+1 for divide-by-zero).
REQ-026 RESP: rsp_valid high; rsp_out, rsp_R, rsp_id, rsp_dz stable until the handshake cycle (rsp_valid & rsp_ready), then IDLE.
REQ-027 No grant occurs in the handshake cycle; earliest next req_ready is the cycle after return to IDLE.
REQ-028 req_ready SHALL be 0 in EXEC and RESP; new requests wait.
REQ-029 rsp_R SHALL be forced to 0 on capture for Sel other than 11.

Reset
REQ-030 Rst SHALL take priority over every other input in the same cycle.
REQ-031 After Rst: state IDLE, pointer = 0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_R=0, rsp_dz=0, busy=0, operand registers 0.
REQ-032 Rst during EXEC or RESP SHALL abort the operation with no response issued.
REQ-033 The datapath Rst input SHALL be driven from the block's Rst.

Structure
REQ-034 Package calc_pkg SHALL hold the opcode constants (OP_ADD..OP_DIV), FSM state encoding and the operand width constant (8).
REQ-035 Sub-module rr_arb2 SHALL implement the two-way round-robin grant and pointer; the Calculator datapath is instantiated once inside calc_arbiter.

Verification
REQ-036 Req0 add A=5,B=3, signs 0, SETTLE=2, rsp_ready=1 -> req_ready=01, rsp_valid at grant+3, rsp_out=8, rsp_R=0, rsp_id=0.
REQ-037 Both valid after reset, req0 mul 12x10, req1 div 100/7 -> req0 served first (rsp_out=120), then req1 (rsp_out=14, rsp_R=2, rsp_id=1).
REQ-038 Req1 div A=9,B=0 -> rsp_valid at grant+1, rsp_dz=1, rsp_out=0, rsp_R=0.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready stays 00 despite pending req0, grant one cycle after handshake.
REQ-040 Rst asserted in second EXEC cycle -> next cycle all outputs at reset values, no rsp_valid, pointer 0.
